// File: rtl/router_out_arb.sv
// router_out_arb: packet-level round-robin arbiter draining three FIFOs onto one valid/ready egress channel
module router_out_arb #(
    parameter int STALL_MAX = 30
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [2:0] vld_in,
    input  logic [7:0] din_0,
    input  logic [7:0] din_1,
    input  logic [7:0] din_2,
    output logic [2:0] read_enb,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       dout_last,
    output logic [2:0] grant,
    output logic       busy,
    output logic       stall_err
);
    typedef enum logic [2:0] {IDLE, RD_HDR, WAIT_HDR, RD_BODY, DRAIN} state_t;
    localparam int CW = $clog2(STALL_MAX + 1);

    state_t          state, state_nxt;
    logic [1:0]      ptr, gidx, n1, n2, sel;
    logic [6:0]      remaining;
    logic [CW-1:0]   stall_cnt;
    logic            inflight, inflight_last;
    logic [1:0][7:0] buf_data;
    logic [1:0]      buf_last;
    logic            rd_ptr, wr_ptr;
    logic [1:0]      occ;
    logic [7:0]      din_g;
    logic            vld_g, pop, room, rd, abort, release_g;

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return x == 2'd2 ? 2'd0 : x + 2'd1;
    endfunction

    // Selection, read issue (a slot freed by this cycle's pop may be refilled at once) and buffer head view
    always_comb begin
        n1         = inc3(ptr);
        n2         = inc3(n1);
        sel        = vld_in[ptr] ? ptr : vld_in[n1] ? n1 : n2;
        vld_g      = |(grant & vld_in);
        din_g      = gidx == 2'd0 ? din_0 : gidx == 2'd1 ? din_1 : din_2;
        dout_valid = occ != 2'd0;
        dout       = buf_data[rd_ptr];
        dout_last  = dout_valid & buf_last[rd_ptr];
        pop        = dout_valid & dout_ready;
        room       = ({1'b0, occ} + {2'b0, inflight} - {2'b0, pop}) < 3'd2;
        rd         = vld_g & room & (state == RD_HDR || state == RD_BODY);
        read_enb   = rd ? grant : 3'b000;
        abort      = state == RD_BODY && !vld_g && stall_cnt == CW'(STALL_MAX - 1);
        release_g  = abort || (state == DRAIN && occ == 2'd0 && !inflight);
        busy       = |grant;
    end

    // Next-state logic of the packet sequencer
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = |vld_in ? RD_HDR : IDLE;
            RD_HDR:   state_nxt = rd ? WAIT_HDR : RD_HDR;
            WAIT_HDR: state_nxt = inflight ? RD_BODY : WAIT_HDR;
            RD_BODY:  state_nxt = abort ? IDLE : (rd && remaining == 7'd1) ? DRAIN : RD_BODY;
            DRAIN:    state_nxt = release_g ? IDLE : DRAIN;
            default:  state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Grant ownership, round-robin pointer, byte countdown and stall watchdog
    always_ff @(posedge clock) begin
        if (!resetn) begin
            grant         <= '0;
            gidx          <= '0;
            ptr           <= '0;
            remaining     <= '0;
            stall_cnt     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            stall_err     <= 1'b0;
        end else begin
            inflight      <= rd;
            inflight_last <= rd && state == RD_BODY && remaining == 7'd1;
            stall_err     <= abort;
            if (state == IDLE && |vld_in) begin
                grant <= 3'b001 << sel;
                gidx  <= sel;
            end else if (release_g) begin
                grant <= '0;
                ptr   <= inc3(gidx);
            end
            if (state == WAIT_HDR && inflight)
                remaining <= {1'b0, din_g[7:2]} + 7'd1;
            else if (rd && state == RD_BODY)
                remaining <= remaining - 7'd1;
            stall_cnt <= (rd || state != RD_BODY) ? '0 : !vld_g ? stall_cnt + CW'(1) : stall_cnt;
        end
    end

    // Two-entry skid buffer: push returning bytes, pop on handshake, flush on stall abort
    always_ff @(posedge clock) begin
        if (!resetn || abort) begin
            occ      <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            buf_data <= '0;
            buf_last <= '0;
        end else begin
            if (inflight) begin
                buf_data[wr_ptr] <= din_g;
                buf_last[wr_ptr] <= inflight_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, inflight} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_router_out_arb.sv
// tb_router_out_arb: randomized and directed checks of router_out_arb against a packet-level model
module tb_router_out_arb;
    localparam int STALL_MAX = 30;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [2:0] vld_in = '0;
    logic [7:0] din_0 = '0, din_1 = '0, din_2 = '0;
    logic       dout_ready = 1'b0;
    logic [2:0] read_enb, grant;
    logic [7:0] dout;
    logic       dout_valid, dout_last, busy, stall_err;

    router_out_arb #(.STALL_MAX(STALL_MAX)) dut (
        .clock(clock), .resetn(resetn), .vld_in(vld_in),
        .din_0(din_0), .din_1(din_1), .din_2(din_2),
        .read_enb(read_enb), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .dout_last(dout_last), .grant(grant),
        .busy(busy), .stall_err(stall_err)
    );

    always #5 clock = ~clock;

    int total = 0, bad = 0;
    logic [7:0] fq[3][$];
    logic [7:0] eq[3][$];
    int plen[3][$];
    bit ptrunc[3][$];
    int gh[$], xc[$];
    int cyc = 0, p = 0, cur = -1, n = 0, sent = 0, last_rd = 0, stalls = 0, occ = 0, ready_mode = 0;
    bit trunc = 0, was_rst = 0, r1 = 0, r2 = 0, pop1 = 0;
    logic [2:0] renb_s = '0, prev_vld = '0, prev_grant = '0;
    logic prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0;
    logic [7:0] prev_dout = '0;
    int rr_exp[5] = '{1, 2, 4, 1, 4};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int rr(input int ptr, input logic [2:0] v);
        for (int k = 0; k < 3; k++)
            if (v[(ptr + k) % 3]) return (ptr + k) % 3;
        return -1;
    endfunction

    task automatic load_pkt(input int f, input int len, input int supply, input logic [1:0] addr, input logic [7:0] seed);
        logic [7:0] h, b, par;
        h = {len[5:0], addr};
        par = h;
        fq[f].push_back(h);
        eq[f].push_back(h);
        for (int k = 0; k < supply; k++) begin
            b = seed != 0 ? 8'(seed * (k + 1)) : 8'($urandom);
            par ^= b;
            fq[f].push_back(b);
            eq[f].push_back(b);
        end
        if (supply == len) begin
            fq[f].push_back(par);
            eq[f].push_back(par);
        end
        plen[f].push_back(supply == len ? len + 2 : supply + 1);
        ptrunc[f].push_back(supply != len);
    endtask

    task automatic drive();
        logic [7:0] b;
        for (int i = 0; i < 3; i++)
            if (renb_s[i]) begin
                check("rd_nonempty", fq[i].size() > 0, 1);
                b = fq[i].size() > 0 ? fq[i].pop_front() : 8'h00;
                if (i == 0) din_0 = b;
                else if (i == 1) din_1 = b;
                else din_2 = b;
            end
        vld_in = {fq[2].size() > 0, fq[1].size() > 0, fq[0].size() > 0};
        dout_ready = ready_mode == 0 ? 1'b1 :
                     ready_mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) :
                     ($urandom_range(0, 3) != 0);
    endtask

    task automatic monitor();
        int e, gi;
        logic [7:0] ex;
        cyc++;
        if (was_rst) begin
            check("rst_outs", {read_enb, dout, dout_valid, dout_last, grant, busy, stall_err}, 0);
            if (cur >= 0) begin
                fq[cur].delete();
                eq[cur].delete();
                plen[cur].delete();
                ptrunc[cur].delete();
            end
            cur = -1; p = 0; occ = 0; r1 = 0; r2 = 0; pop1 = 0;
            prev_grant = '0; prev_valid = 1'b0; prev_vld = vld_in; renb_s = read_enb;
            return;
        end
        occ = occ + int'(r2) - int'(pop1);
        if (stall_err) occ = 0;
        check("occ_max", occ <= 2, 1);
        check("dout_valid", dout_valid, occ > 0);
        check("renb_legal", read_enb & ~(grant & vld_in), 0);
        check("renb_onehot", $countones(read_enb) <= 1, 1);
        check("grant_onehot", $countones(grant) <= 1, 1);
        check("busy", busy, |grant);
        if (prev_valid && !prev_ready && !stall_err)
            check("hold", {dout_valid, dout_last, dout}, {1'b1, prev_last, prev_dout});
        if (dout_valid && dout_ready) begin
            xc.push_back(cyc);
            check("xfer_expected", cur >= 0 && sent < n && (cur < 0 ? 0 : eq[cur].size()) > 0, 1);
            if (cur >= 0 && sent < n && eq[cur].size() > 0) begin
                ex = eq[cur].pop_front();
                check("byte", dout, ex);
                check("last", dout_last, !trunc && sent == n - 1);
                sent++;
            end
        end
        if (prev_grant == 0 && grant != 0) begin
            e = rr(p, prev_vld);
            gi = grant[0] ? 0 : grant[1] ? 1 : 2;
            check("grant_pick", gi, e);
            gh.push_back(int'(grant));
            cur = gi;
            sent = 0;
            check("pkt_avail", plen[gi].size() > 0, 1);
            if (plen[gi].size() > 0) begin
                n = plen[gi].pop_front();
                trunc = ptrunc[gi].pop_front();
            end else begin
                n = 0;
                trunc = 0;
            end
        end else if (prev_grant != 0) begin
            if (grant == 0) begin
                check("stall_match", stall_err, trunc);
                if (stall_err) begin
                    check("stall_time", cyc - last_rd, STALL_MAX + 1);
                    for (int k = sent; k < n; k++)
                        if (eq[cur].size() > 0) eq[cur].delete(0);
                end else
                    check("pkt_len", sent, n);
                p = (cur + 1) % 3;
                cur = -1;
            end else
                check("grant_stable", grant, prev_grant);
        end
        if (stall_err) stalls++;
        if (stall_err && !(prev_grant != 0 && grant == 0))
            check("stall_spurious", stall_err, 0);
        if (read_enb != 0) last_rd = cyc;
        r2 = r1;
        r1 = read_enb != 0;
        pop1 = dout_valid & dout_ready;
        prev_valid = dout_valid;
        prev_ready = dout_ready;
        prev_last = dout_last;
        prev_dout = dout;
        prev_grant = grant;
        prev_vld = vld_in;
        renb_s = read_enb;
    endtask

    task automatic step();
        @(posedge clock);
        was_rst = !resetn;
        #1;
        drive();
        @(negedge clock);
        monitor();
    endtask

    task automatic run_idle(input int budget);
        int k;
        k = 0;
        while (k < budget && !(fq[0].size() == 0 && fq[1].size() == 0 && fq[2].size() == 0 &&
               eq[0].size() == 0 && eq[1].size() == 0 && eq[2].size() == 0 &&
               grant == 0 && !dout_valid)) begin
            step();
            k++;
        end
        check("drain_in_time", k < budget, 1);
        repeat (2) step();
    endtask

    initial begin
        int k, len;
        ready_mode = 0;
        dout_ready = 1'b1;
        load_pkt(0, 0, 0, 2'd0, 8'h00);
        load_pkt(1, 0, 0, 2'd1, 8'h00);
        load_pkt(2, 0, 0, 2'd2, 8'h00);
        vld_in = 3'b111;
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
        gh.delete();
        run_idle(300);
        load_pkt(0, 1, 1, 2'd0, 8'h00);
        step();
        load_pkt(2, 2, 2, 2'd2, 8'h00);
        run_idle(300);
        check("rr_count", gh.size(), 5);
        if (gh.size() == 5)
            for (int i = 0; i < 5; i++) check("rr_seq", gh[i], rr_exp[i]);

        gh.delete();
        xc.delete();
        load_pkt(1, 3, 3, 2'd1, 8'h11);
        run_idle(300);
        check("single_grant", gh.size() == 1 ? gh[0] : 0, 2);
        check("single_count", xc.size(), 5);
        if (xc.size() == 5) check("single_rate", xc[4] - xc[1], 3);

        ready_mode = 1;
        load_pkt(2, 5, 5, 2'd3, 8'h00);
        run_idle(500);
        ready_mode = 0;

        stalls = 0;
        gh.delete();
        load_pkt(0, 10, 4, 2'd0, 8'h00);
        load_pkt(1, 2, 2, 2'd1, 8'h00);
        run_idle(500);
        check("stall_pulses", stalls, 1);
        check("stall_next", gh.size() == 2 ? gh[1] : 0, 2);

        gh.delete();
        load_pkt(1, 8, 8, 2'd2, 8'h00);
        k = 0;
        while (k < 300 && !(cur == 1 && sent >= 2)) begin
            step();
            k++;
        end
        check("reached_mid", cur == 1 && sent >= 2, 1);
        resetn = 1'b0;
        step();
        step();
        load_pkt(0, 1, 1, 2'd0, 8'h00);
        load_pkt(2, 1, 1, 2'd2, 8'h00);
        resetn = 1'b1;
        run_idle(300);
        check("rst_grants", gh.size(), 3);
        check("rst_first", gh.size() == 3 ? gh[1] : 0, 1);

        ready_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                len = $urandom_range(0, 9) == 0 ? 63 : $urandom_range(0, 12);
                load_pkt($urandom_range(0, 2), len, len, 2'($urandom), 8'h00);
            end
            step();
        end
        run_idle(20000);
        check("leftover", eq[0].size() + eq[1].size() + eq[2].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/router_out_arb.md
Name: router_out_arb

Overview:
- Packet-level round-robin read arbiter that drains the three router output FIFOs onto one shared 8-bit egress channel with a valid/ready handshake.
- Sits downstream of the three FIFO instances. Drives their read enables and consumes their data_out and valid (non-empty) flags.
- Forwards whole packets (header, payload, parity) without interleaving, and releases the grant only after the parity byte is read.

Parameters:
- STALL_MAX, 30, number of consecutive cycles the granted FIFO may stay empty mid-packet before the packet is aborted.

Ports:
- clock  in  1  system clock, all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- vld_in  in  3  FIFO i non-empty (vld_out_i)
- din_0  in  8  FIFO 0 data_out
- din_1  in  8  FIFO 1 data_out
- din_2  in  8  FIFO 2 data_out
- read_enb  out  3  one-hot read enable to FIFO i
- dout  out  8  egress byte
- dout_valid  out  1  egress byte valid
- dout_ready  in  1  egress sink accepts byte
- dout_last  out  1  marks the parity (final) byte of a packet
- grant  out  3  one-hot owner of the channel, 0 when idle
- busy  out  1  packet in progress (grant != 0)
- stall_err  out  1  one-cycle pulse on mid-packet timeout abort

Behaviour:
- Reset (resetn=0 at a clock edge): all outputs are 0. State goes to IDLE, the round-robin pointer goes to 0, the skid buffer is emptied and the counters are cleared. FIFO contents are not touched.
- FIFO read latency is 1: din_i is valid the cycle after read_enb[i] is sampled high. read_enb[i] is asserted only when grant[i]=1 and vld_in[i]=1.
- Packet format: header byte [7:2]=payload length L (0..63) and [1:0]=address. Then L payload bytes, then 1 parity byte. Total L+2 bytes.
- Egress buffer: 2-entry FIFO skid buffer.
  - A read may be issued only when (buffer occupancy + reads in flight) < 2.
  - dout/dout_valid/dout_last always come from the buffer head.
  - A byte transfers when dout_valid and dout_ready are both high.
  - While dout_valid=1 and dout_ready=0, dout and dout_last hold stable.
- State machine:
  - IDLE: pick the first i with vld_in[i]=1, searching from pointer p upward modulo 3. Assert grant[i] the next cycle and go to RD_HDR. If none is valid, stay in IDLE.
  - RD_HDR: issue one read when allowed, then go to WAIT_HDR.
  - WAIT_HDR: on header return, load remaining = L+1 and go to RD_BODY.
  - RD_BODY: issue reads while remaining>0, decrementing per read issued. When remaining reaches 0, go to DRAIN.
  - DRAIN: once the buffer is empty and no read is in flight, clear grant, set p = (i+1) mod 3 and go to IDLE.
  - A new grant is never issued the same cycle the old one is released. There is at least 1 IDLE cycle between packets.
- dout_last is set on the entry holding the byte read when remaining went 1 to 0. For L=0 this is the second byte.
- Stall watchdog:
  - In RD_BODY, count consecutive cycles with remaining>0 and vld_in[i]=0. The counter resets on any read.
  - When the count reaches STALL_MAX, pulse stall_err for 1 cycle, flush the buffer (no further dout_valid for this packet), clear grant, set p=(i+1) mod 3 and go to IDLE.
  - Bytes already transferred are not recalled.
- Simultaneous events: a buffer push and pop in the same cycle leaves the occupancy unchanged. A reset asserted mid-packet wins over everything: the packet is dropped, with no dout_last or stall_err.
- grant is stable for the whole packet. busy = |grant.

Test Plan:
- Reset: drive resetn=0 for 2 cycles with vld_in=3'b111 -> read_enb=0, dout_valid=0, grant=0, busy=0, stall_err=0.
- Single packet: FIFO1 holds header 8'h0D (L=3, addr 1), payload 11 22 33, parity P, dout_ready=1 -> grant=3'b010; 5 bytes out in order; dout_last only on P; after throughput ramp-up, 1 byte per cycle; grant returns to 0.
- Round-robin: FIFO0, FIFO1 and FIFO2 each hold a 2-byte packet (L=0) with all vld_in high from reset -> grant sequence 001, 010, 100; then a new FIFO0 packet is granted before a FIFO2 packet that arrives later.
- Back-pressure: L=5 packet on FIFO2, dout_ready toggles 1,0,0,1 repeatedly -> no byte lost or duplicated; dout holds stable while ready=0; read_enb never raises occupancy above 2.
- Stall abort (STALL_MAX=30): FIFO0 header says L=10, only 4 payload bytes supplied -> stall_err pulses once 30 cycles after the last read; grant clears; a pending FIFO1 packet is served next.
- Reset mid-packet: assert resetn=0 during byte 3 of an L=8 packet -> the next cycle shows all outputs 0; after release, p=0 and FIFO0 is served first.
